fetch_warp_scheduler: RTL

- Per-cycle warp scheduler for the dual-port instruction fetch stage.
- Each cycle it picks up to two distinct eligible warps out of 8 and drives the registered one-hot grant vectors that select fetch port 0 and fetch port 1.
- Tracks per-warp instruction-buffer credits so a warp is never fetched beyond its IBuffer capacity.
- Uses round-robin fairness and enforces a one-cycle cooldown so a warp's PC can advance between fetches.

---
 rtl/fetch_warp_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_warp_scheduler.sv
// ----------------------------------------------------------------------------
// fetch_warp_scheduler
//
// Per-cycle warp scheduler for the dual-port instruction fetch stage. Each
// cycle it picks up to two distinct eligible warps (round-robin from r_rr_ptr)
// and registers them as one-hot grants for fetch port 0 and fetch port 1.
// Per-warp IBuffer credits stop a warp from being fetched beyond its buffer
// capacity. A warp granted in the current output cycle sits out the next edge
// (cooldown) so its PC can advance.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset
//   Fetch_En     global fetch enable; 0 blocks new grants (credits still update)
//   Warp_Active  [8] warp has a valid PC
//   Warp_Stall   [8] warp blocked from fetch
//   Flush_Warp   [8] warp redirect this cycle; refills credit to IBUF_DEPTH
//   Dequeue_IB   [8] one IBuffer entry of the warp consumed this cycle
//   GRT_raw_1    [8] registered one-hot grant for fetch port 0, or zero
//   GRT_raw_2    [8] registered one-hot grant for fetch port 1, or zero
//   Credit_Zero  [8] warp currently has no IBuffer credit
// ----------------------------------------------------------------------------
module fetch_warp_scheduler #(
  parameter int NUM_WARPS  = 8,
  parameter int IBUF_DEPTH = 2,
  parameter int CRED_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Fetch_En,
  input  logic [NUM_WARPS-1:0] Warp_Active,
  input  logic [NUM_WARPS-1:0] Warp_Stall,
  input  logic [NUM_WARPS-1:0] Flush_Warp,
  input  logic [NUM_WARPS-1:0] Dequeue_IB,
  output logic [NUM_WARPS-1:0] GRT_raw_1,
  output logic [NUM_WARPS-1:0] GRT_raw_2,
  output logic [NUM_WARPS-1:0] Credit_Zero
);

  localparam int                PTR_W    = $clog2(NUM_WARPS);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(IBUF_DEPTH);

  logic [NUM_WARPS-1:0] r_grt1;
  logic [NUM_WARPS-1:0] r_grt2;
  logic [CRED_W-1:0]    r_credit [NUM_WARPS];
  logic [PTR_W-1:0]     r_rr_ptr;

  logic [NUM_WARPS-1:0] w_elig;
  logic                 w_found1;
  logic                 w_found2;
  logic [PTR_W-1:0]     w_g1;
  logic [PTR_W-1:0]     w_g2;
  logic [NUM_WARPS-1:0] w_sel1;
  logic [NUM_WARPS-1:0] w_sel2;
  logic [NUM_WARPS-1:0] w_granted;
  logic [PTR_W-1:0]     w_rr_next;
  logic [CRED_W-1:0]    w_credit_next [NUM_WARPS];

  // Eligibility. The last term is the cooldown: a warp showing on either
  // grant output right now cannot be picked again at this edge.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_elig[w] = Warp_Active[w] & ~Warp_Stall[w] & ~Flush_Warp[w] &
                  (r_credit[w] != '0) & ~(r_grt1[w] | r_grt2[w]);
    end
  end

  // Circular scan from r_rr_ptr: the first eligible warp goes to port 0, the
  // second one met in the same scan (i.e. the scan continued from g1+1) goes
  // to port 1.
  always_comb begin
    logic [PTR_W-1:0] idx;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value held and no latch is inferred.
    w_found1 = 1'b0;
    w_found2 = 1'b0;
    w_g1     = '0;
    w_g2     = '0;
    idx      = '0;
    if (Fetch_En) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        idx = r_rr_ptr + PTR_W'(i);
        if (w_elig[idx]) begin
          if (!w_found1) begin
            w_found1 = 1'b1;
            w_g1     = idx;
          end else if (!w_found2) begin
            w_found2 = 1'b1;
            w_g2     = idx;
          end
        end
      end
    end

    w_sel1 = '0;
    w_sel2 = '0;
    if (w_found1) w_sel1[w_g1] = 1'b1;
    if (w_found2) w_sel2[w_g2] = 1'b1;
    w_granted = w_sel1 | w_sel2;

    // Pointer moves just past the last warp granted; held when idle.
    if (w_found2)      w_rr_next = w_g2 + PTR_W'(1);
    else if (w_found1) w_rr_next = w_g1 + PTR_W'(1);
    else               w_rr_next = r_rr_ptr;
  end

  // Credit bookkeeping. A flush drops every in-flight entry of the warp, so
  // the credit returns to full and a same-cycle dequeue is meaningless.
  always_comb begin
    logic [CRED_W:0] sum;
    sum = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      sum = {1'b0, r_credit[w]} + (CRED_W+1)'(Dequeue_IB[w])
            - (CRED_W+1)'(w_granted[w]);
      if (Flush_Warp[w])                w_credit_next[w] = CRED_MAX;
      else if (sum > {1'b0, CRED_MAX})  w_credit_next[w] = CRED_MAX;
      else                              w_credit_next[w] = sum[CRED_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the credit array is control state, not data storage, so every
      // entry is reset; leaving it unreset would let X credits block fetch.
      r_grt1   <= '0;
      r_grt2   <= '0;
      r_rr_ptr <= '0;
      for (int w = 0; w < NUM_WARPS; w++) r_credit[w] <= CRED_MAX;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      r_grt1   <= w_sel1;
      r_grt2   <= w_sel2;
      r_rr_ptr <= w_rr_next;
      for (int w = 0; w < NUM_WARPS; w++) r_credit[w] <= w_credit_next[w];
    end
  end

  assign GRT_raw_1 = r_grt1;
  assign GRT_raw_2 = r_grt2;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) Credit_Zero[w] = (r_credit[w] == '0);
  end

  // Protocol and integrity checks.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_chk
    // Dequeue on a full warp (no flush, no grant to offset it) is an
    // upstream error; the credit saturates.
    a_credit_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(Dequeue_IB[w] && !Flush_Warp[w] && !w_granted[w] &&
        r_credit[w] == CRED_MAX))
      else $error("credit overflow on warp %0d", w);

    a_credit_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(w_granted[w] && r_credit[w] == '0))
      else $error("credit underflow on warp %0d", w);
  end

  a_grant_onehot : assert property (@(posedge clk)
    $onehot0(r_grt1) && $onehot0(r_grt2) && ((r_grt1 & r_grt2) == '0))
    else $error("grant vectors not one-hot/disjoint");

endmodule
